// File: rtl/tokenizer_pkg.sv
// rtl/tokenizer_pkg.sv - token kinds, operator/keyword codes, lexer states and byte classes
package tokenizer_pkg;

  typedef enum logic [2:0] {
    K_RESERVED = 3'd0,
    K_IDENT    = 3'd1,
    K_NUM      = 3'd2,
    K_EOF      = 3'd3,
    K_ERR      = 3'd4
  } kind_t;

  typedef enum logic [1:0] {S_SCAN, S_NUM, S_IDENT, S_OP2} state_t;

  localparam logic [4:0] OP_LE     = 5'd14;
  localparam logic [4:0] OP_GE     = 5'd15;
  localparam logic [4:0] OP_EQ     = 5'd16;
  localparam logic [4:0] OP_NE     = 5'd17;
  localparam logic [4:0] OP_RETURN = 5'd18;
  localparam logic [4:0] OP_IF     = 5'd19;
  localparam logic [4:0] OP_ELSE   = 5'd20;
  localparam logic [4:0] OP_FOR    = 5'd21;
  localparam logic [4:0] OP_WHILE  = 5'd22;

  // Keywords packed first-character-in-low-byte, matching out_name layout
  localparam logic [47:0] KW_RETURN = {"n", "r", "u", "t", "e", "r"};
  localparam logic [15:0] KW_IF     = {"f", "i"};
  localparam logic [31:0] KW_ELSE   = {"e", "s", "l", "e"};
  localparam logic [23:0] KW_FOR    = {"r", "o", "f"};
  localparam logic [39:0] KW_WHILE  = {"e", "l", "i", "h", "w"};

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic logic is_word(input logic [7:0] c);
    return is_digit(c) || ((c >= "a") && (c <= "z")) || ((c >= "A") && (c <= "Z")) || (c == "_");
  endfunction

  function automatic logic is_space(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic is_op2(input logic [7:0] c);
    return (c == "<") || (c == ">") || (c == "=") || (c == "!");
  endfunction

  // Zero means the byte is not a single-character operator
  function automatic logic [4:0] op1_code(input logic [7:0] c);
    case (c)
      "+":     return 5'd1;
      "-":     return 5'd2;
      "*":     return 5'd3;
      "/":     return 5'd4;
      "(":     return 5'd5;
      ")":     return 5'd6;
      "{":     return 5'd7;
      "}":     return 5'd8;
      ";":     return 5'd9;
      ",":     return 5'd10;
      "<":     return 5'd11;
      ">":     return 5'd12;
      "=":     return 5'd13;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] op2_code(input logic [7:0] first);
    case (first)
      "<":     return OP_LE;
      ">":     return OP_GE;
      "=":     return OP_EQ;
      default: return OP_NE;
    endcase
  endfunction

endpackage

// File: rtl/tok_classify.sv
// rtl/tok_classify.sv - combinational keyword lookup on a packed identifier
module tok_classify
  import tokenizer_pkg::*;
#(
  parameter int MAX_ID_LEN = 8
) (
  input  logic [8*MAX_ID_LEN-1:0] name,
  input  logic [3:0]              len,
  output logic                    is_kw,
  output logic [4:0]              op
);
  localparam int W = 8 * MAX_ID_LEN;

  // Unused name bytes are always zero, so a zero-extended compare plus length is exact
  always_comb begin
    is_kw = 1'b1;
    op    = '0;
    if (len == 4'd6 && name == W'(KW_RETURN))     op = OP_RETURN;
    else if (len == 4'd2 && name == W'(KW_IF))    op = OP_IF;
    else if (len == 4'd4 && name == W'(KW_ELSE))  op = OP_ELSE;
    else if (len == 4'd3 && name == W'(KW_FOR))   op = OP_FOR;
    else if (len == 4'd5 && name == W'(KW_WHILE)) op = OP_WHILE;
    else is_kw = 1'b0;
  end

endmodule

// File: rtl/tokenizer.sv
// rtl/tokenizer.sv - byte-stream lexer emitting one registered token per handshake
module tokenizer
  import tokenizer_pkg::*;
#(
  parameter int MAX_ID_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_kind,
  output logic [4:0]              out_op,
  output logic [31:0]             out_val,
  output logic [8*MAX_ID_LEN-1:0] out_name,
  output logic [3:0]              out_len
);
  localparam int W = 8 * MAX_ID_LEN;
  localparam logic [3:0] MAX_LEN = 4'(MAX_ID_LEN);

  state_t        state;
  logic [31:0]   val_acc;
  logic [W-1:0]  name_acc;
  logic [3:0]    len_acc;
  logic          trunc_acc;
  logic [7:0]    op_first;
  logic          replay_valid;
  logic [7:0]    replay_data;
  logic          replay_last;
  logic          eof_pend;

  logic          slot_free, take, last, cont, emit, to_replay;
  logic [7:0]    b, sx;
  logic [31:0]   num_next;
  logic [W-1:0]  id_name;
  logic [3:0]    id_len;
  logic          id_trunc, kw_hit;
  logic [4:0]    kw_op;
  kind_t         e_kind;
  logic [4:0]    e_op;
  logic [31:0]   e_val;
  logic [W-1:0]  e_name;
  logic [3:0]    e_len;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && !replay_valid && !eof_pend && slot_free;
  // A pending replay byte always wins over the input port
  assign take      = replay_valid ? slot_free : (in_valid && in_ready);
  assign b         = replay_valid ? replay_data : in_data;
  assign last      = replay_valid ? replay_last : in_last;
  assign num_next  = val_acc * 32'd10 + {28'd0, b[3:0]};

  always_comb begin
    id_name  = name_acc;
    id_len   = len_acc;
    id_trunc = trunc_acc;
    if (is_word(b)) begin
      if (len_acc < MAX_LEN) begin
        id_name[8*len_acc +: 8] = b;
        id_len = len_acc + 4'd1;
      end else begin
        id_trunc = 1'b1;
      end
    end
  end

  tok_classify #(.MAX_ID_LEN(MAX_ID_LEN)) u_classify (
    .name  (id_name),
    .len   (id_len),
    .is_kw (kw_hit),
    .op    (kw_op)
  );

  // Token that would be produced if this cycle's byte ends or completes one
  always_comb begin
    sx        = (state == S_OP2) ? op_first : b;
    cont      = (state == S_NUM) ? is_digit(b) : ((state == S_IDENT) ? is_word(b) : 1'b0);
    e_kind    = K_RESERVED;
    e_op      = '0;
    e_val     = '0;
    e_name    = '0;
    e_len     = '0;
    emit      = 1'b0;
    to_replay = 1'b0;
    if (state == S_SCAN && is_space(b)) begin
      e_kind = K_EOF;
    end else if (state == S_NUM || (state == S_SCAN && is_digit(b))) begin
      e_kind = K_NUM;
      e_val  = is_digit(b) ? num_next : val_acc;
    end else if (state == S_IDENT || (state == S_SCAN && is_word(b))) begin
      e_kind = (kw_hit && !id_trunc) ? K_RESERVED : K_IDENT;
      e_op   = (kw_hit && !id_trunc) ? kw_op : 5'd0;
      e_name = id_name;
      e_len  = id_len;
    end else if (state == S_OP2 && b == "=") begin
      e_op = op2_code(op_first);
    end else if (op1_code(sx) != 5'd0) begin
      e_op = op1_code(sx);
    end else begin
      e_kind = K_ERR;
      e_val  = {24'd0, sx};
    end
    case (state)
      S_SCAN:  emit = is_space(b) ? last : (last || !is_word(b) && !is_op2(b));
      S_OP2: begin
        emit      = 1'b1;
        to_replay = (b != "=");
      end
      default: begin
        emit      = !cont || last;
        to_replay = !cont;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_SCAN;
      val_acc      <= '0;
      name_acc     <= '0;
      len_acc      <= '0;
      trunc_acc    <= 1'b0;
      op_first     <= '0;
      replay_valid <= 1'b0;
      replay_data  <= '0;
      replay_last  <= 1'b0;
      eof_pend     <= 1'b0;
      out_valid    <= 1'b0;
      out_kind     <= '0;
      out_op       <= '0;
      out_val      <= '0;
      out_name     <= '0;
      out_len      <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (take) begin
        replay_valid <= to_replay;
        replay_data  <= b;
        replay_last  <= last;
        if (emit) begin
          out_valid <= 1'b1;
          out_kind  <= e_kind;
          out_op    <= e_op;
          out_val   <= e_val;
          out_name  <= e_name;
          out_len   <= e_len;
        end
        // A replayed last byte defers EOF until the replay itself is processed
        if (last && !to_replay && !(state == S_SCAN && is_space(b))) eof_pend <= 1'b1;
        if (emit || state == S_OP2) begin
          state     <= S_SCAN;
          val_acc   <= '0;
          name_acc  <= '0;
          len_acc   <= '0;
          trunc_acc <= 1'b0;
        end else begin
          case (state)
            S_SCAN: begin
              if (is_digit(b)) begin
                state   <= S_NUM;
                val_acc <= num_next;
              end else if (is_word(b)) begin
                state     <= S_IDENT;
                name_acc  <= id_name;
                len_acc   <= id_len;
                trunc_acc <= id_trunc;
              end else if (!is_space(b)) begin
                state    <= S_OP2;
                op_first <= b;
              end
            end
            S_NUM: val_acc <= num_next;
            S_IDENT: begin
              name_acc  <= id_name;
              len_acc   <= id_len;
              trunc_acc <= id_trunc;
            end
            default: ;
          endcase
        end
      end else if (eof_pend && slot_free && !replay_valid) begin
        eof_pend  <= 1'b0;
        out_valid <= 1'b1;
        out_kind  <= K_EOF;
        out_op    <= '0;
        out_val   <= '0;
        out_name  <= '0;
        out_len   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tokenizer.sv
// tb/tb_tokenizer.sv - directed scenario bench for the tokenizer
module tb_tokenizer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [2:0]  out_kind;
  logic [4:0]  out_op;
  logic [31:0] out_val;
  logic [63:0] out_name;
  logic [3:0]  out_len;

  int errors = 0;
  int checks = 0;

  logic [2:0]  tk_kind[$];
  logic [4:0]  tk_op[$];
  logic [31:0] tk_val[$];
  logic [63:0] tk_name[$];
  logic [3:0]  tk_len[$];
  bit timed_out, stable_bad, rdy_bad;

  tokenizer #(.MAX_ID_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_op    (out_op),
    .out_val   (out_val),
    .out_name  (out_name),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  // Streams s in, collects tokens until EOF (or idle when no last byte), stalling out_ready
  task automatic run(input string s, input bit with_last, input int stall);
    int idx = 0;
    int wait_cnt = 0;
    int cyc = 0;
    int idle = 0;
    bit done = 0;
    bit hold = 0;
    logic [2:0] hk;
    logic [4:0] ho;
    logic [31:0] hv;
    logic [63:0] hn;
    logic [3:0] hl;
    tk_kind.delete(); tk_op.delete(); tk_val.delete(); tk_name.delete(); tk_len.delete();
    timed_out = 0; stable_bad = 0; rdy_bad = 0;
    while (!done) begin
      @(negedge clk);
      if (hold && (out_valid !== 1'b1 || out_kind !== hk || out_op !== ho || out_val !== hv ||
                   out_name !== hn || out_len !== hl)) stable_bad = 1;
      out_ready = out_valid && (wait_cnt >= stall);
      in_valid  = (idx < s.len());
      in_data   = (idx < s.len()) ? s[idx] : 8'h00;
      in_last   = with_last && (idx == s.len() - 1);
      #1;
      if (out_valid && !out_ready && in_ready) rdy_bad = 1;
      hold = out_valid && !out_ready;
      hk = out_kind; ho = out_op; hv = out_val; hn = out_name; hl = out_len;
      if (out_valid && out_ready) begin
        tk_kind.push_back(out_kind); tk_op.push_back(out_op); tk_val.push_back(out_val);
        tk_name.push_back(out_name); tk_len.push_back(out_len);
        wait_cnt = 0;
        if (out_kind == 3'd3) done = 1;
      end else if (out_valid) begin
        wait_cnt++;
      end
      if (in_valid && in_ready) idx++;
      if (!with_last && idx == s.len()) begin
        idle++;
        if (idle > 3) done = 1;
      end
      cyc++;
      if (cyc > 300) begin
        timed_out = 1;
        done = 1;
      end
    end
    @(negedge clk);
    in_valid = 0; in_last = 0; out_ready = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 7;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    if (out_kind !== 3'd0) begin errors++; $display("FAIL reset_out_kind: got %0d want 0", out_kind); end
    if (out_op !== 5'd0) begin errors++; $display("FAIL reset_out_op: got %0d want 0", out_op); end
    if (out_val !== 32'd0) begin errors++; $display("FAIL reset_out_val: got %0h want 0", out_val); end
    if (out_name !== 64'd0) begin errors++; $display("FAIL reset_out_name: got %h want 0", out_name); end
    if (out_len !== 4'd0) begin errors++; $display("FAIL reset_out_len: got %0d want 0", out_len); end
    rst = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_assign;
    logic [2:0]  ek[5] = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd3};
    logic [31:0] ev[5] = '{32'd0, 32'd13, 32'd3, 32'd9, 32'd0};
    logic [63:0] en[5] = '{64'h61, 64'd0, 64'd0, 64'd0, 64'd0};
    logic [3:0]  el[5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    run("a=3;", 1, 0);
    checks++;
    if (timed_out || tk_kind.size() != 5) begin errors++; $display("FAIL assign_count: got %0d want 5 (timeout=%0b)", tk_kind.size(), timed_out); end
    for (int i = 0; i < 5 && i < tk_kind.size(); i++) begin
      checks++;
      if (tk_kind[i] !== ek[i] || (ek[i] == 0 && tk_op[i] !== ev[i][4:0]) ||
          ((ek[i] == 2 || ek[i] == 4) && tk_val[i] !== ev[i]) ||
          (ek[i] == 1 && (tk_name[i] !== en[i] || tk_len[i] !== el[i]))) begin
        errors++;
        $display("FAIL assign_tok%0d: got kind=%0d op=%0d val=%0h name=%h len=%0d want kind=%0d op/val=%0h name=%h len=%0d", i, tk_kind[i], tk_op[i], tk_val[i], tk_name[i], tk_len[i], ek[i], ev[i], en[i], el[i]);
      end
    end
  endtask

  task automatic test_op2;
    logic [2:0]  ek[7] = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd3, 3'd0};
    logic [31:0] ev[7] = '{32'd0, 32'd14, 32'd10, 32'd11, 32'd0, 32'd0, 32'd0};
    logic [63:0] en[7] = '{64'h78, 64'd0, 64'd0, 64'd0, 64'h79, 64'd0, 64'd0};
    logic [3:0]  el[7] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
    run("x<=10 <y", 1, 0);
    checks++;
    if (timed_out || tk_kind.size() != 6) begin errors++; $display("FAIL op2_count: got %0d want 6 (timeout=%0b)", tk_kind.size(), timed_out); end
    for (int i = 0; i < 6 && i < tk_kind.size(); i++) begin
      checks++;
      if (tk_kind[i] !== ek[i] || (ek[i] == 0 && tk_op[i] !== ev[i][4:0]) ||
          ((ek[i] == 2 || ek[i] == 4) && tk_val[i] !== ev[i]) ||
          (ek[i] == 1 && (tk_name[i] !== en[i] || tk_len[i] !== el[i]))) begin
        errors++;
        $display("FAIL op2_tok%0d: got kind=%0d op=%0d val=%0h name=%h len=%0d want kind=%0d op/val=%0h name=%h len=%0d", i, tk_kind[i], tk_op[i], tk_val[i], tk_name[i], tk_len[i], ek[i], ev[i], en[i], el[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [2:0]  ek[4] = '{3'd0, 3'd2, 3'd0, 3'd3};
    logic [31:0] ev[4] = '{32'd18, 32'd1, 32'd9, 32'd0};
    run("return 4294967297;", 1, 0);
    checks++;
    if (timed_out || tk_kind.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4 (timeout=%0b)", tk_kind.size(), timed_out); end
    for (int i = 0; i < 4 && i < tk_kind.size(); i++) begin
      checks++;
      if (tk_kind[i] !== ek[i] || (ek[i] == 0 && tk_op[i] !== ev[i][4:0]) ||
          (ek[i] == 2 && tk_val[i] !== ev[i])) begin
        errors++;
        $display("FAIL wrap_tok%0d: got kind=%0d op=%0d val=%0h want kind=%0d op/val=%0h", i, tk_kind[i], tk_op[i], tk_val[i], ek[i], ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ek[4] = '{3'd2, 3'd0, 3'd2, 3'd3};
    logic [31:0] ev[4] = '{32'd1, 32'd1, 32'd2, 32'd0};
    run("1+2", 1, 5);
    checks++;
    if (timed_out || tk_kind.size() != 4) begin errors++; $display("FAIL stall_count: got %0d want 4 (timeout=%0b)", tk_kind.size(), timed_out); end
    for (int i = 0; i < 4 && i < tk_kind.size(); i++) begin
      checks++;
      if (tk_kind[i] !== ek[i] || (ek[i] == 0 && tk_op[i] !== ev[i][4:0]) ||
          (ek[i] == 2 && tk_val[i] !== ev[i])) begin
        errors++;
        $display("FAIL stall_tok%0d: got kind=%0d op=%0d val=%0h want kind=%0d op/val=%0h", i, tk_kind[i], tk_op[i], tk_val[i], ek[i], ev[i]);
      end
    end
    checks += 2;
    if (stable_bad) begin errors++; $display("FAIL stall_hold: outputs changed while stalled, got 1 want 0"); end
    if (rdy_bad) begin errors++; $display("FAIL stall_in_ready: in_ready high while stalled, got 1 want 0"); end
  endtask

  task automatic test_err_trunc;
    logic [2:0]  ek[5] = '{3'd1, 3'd4, 3'd1, 3'd1, 3'd3};
    logic [31:0] ev[5] = '{32'd0, 32'h40, 32'd0, 32'd0, 32'd0};
    logic [63:0] en[5] = '{64'h6261, 64'd0, 64'h0000_7865_6c69_6877, 64'h6867_6665_6463_6261, 64'd0};
    logic [3:0]  el[5] = '{4'd2, 4'd0, 4'd6, 4'd8, 4'd0};
    run("ab@ whilex abcdefghij", 1, 0);
    checks++;
    if (timed_out || tk_kind.size() != 5) begin errors++; $display("FAIL err_count: got %0d want 5 (timeout=%0b)", tk_kind.size(), timed_out); end
    for (int i = 0; i < 5 && i < tk_kind.size(); i++) begin
      checks++;
      if (tk_kind[i] !== ek[i] || ((ek[i] == 2 || ek[i] == 4) && tk_val[i] !== ev[i]) ||
          (ek[i] == 1 && (tk_name[i] !== en[i] || tk_len[i] !== el[i]))) begin
        errors++;
        $display("FAIL err_tok%0d: got kind=%0d val=%0h name=%h len=%0d want kind=%0d val=%0h name=%h len=%0d", i, tk_kind[i], tk_val[i], tk_name[i], tk_len[i], ek[i], ev[i], en[i], el[i]);
      end
    end
  endtask

  task automatic test_keywords;
    logic [2:0]  ek[6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3};
    logic [31:0] ev[6] = '{32'd19, 32'd20, 32'd21, 32'd22, 32'h21, 32'd0};
    run("if else for while! ", 1, 0);
    checks++;
    if (timed_out || tk_kind.size() != 6) begin errors++; $display("FAIL kw_count: got %0d want 6 (timeout=%0b)", tk_kind.size(), timed_out); end
    for (int i = 0; i < 6 && i < tk_kind.size(); i++) begin
      checks++;
      if (tk_kind[i] !== ek[i] || (ek[i] == 0 && tk_op[i] !== ev[i][4:0]) ||
          (ek[i] == 4 && tk_val[i] !== ev[i])) begin
        errors++;
        $display("FAIL kw_tok%0d: got kind=%0d op=%0d val=%0h want kind=%0d op/val=%0h", i, tk_kind[i], tk_op[i], tk_val[i], ek[i], ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0]  ek[2] = '{3'd2, 3'd3};
    logic [31:0] ev[2] = '{32'd7, 32'd0};
    run("12", 0, 0);
    checks++;
    if (tk_kind.size() != 0) begin errors++; $display("FAIL mid_partial: got %0d tokens want 0", tk_kind.size()); end
    @(negedge clk);
    rst = 1;
    #1;
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %0b want 0", out_valid); end
    @(negedge clk);
    rst = 0;
    run("7", 1, 0);
    checks++;
    if (timed_out || tk_kind.size() != 2) begin errors++; $display("FAIL mid_count: got %0d want 2 (timeout=%0b)", tk_kind.size(), timed_out); end
    for (int i = 0; i < 2 && i < tk_kind.size(); i++) begin
      checks++;
      if (tk_kind[i] !== ek[i] || (ek[i] == 2 && tk_val[i] !== ev[i])) begin
        errors++;
        $display("FAIL mid_tok%0d: got kind=%0d val=%0d want kind=%0d val=%0d", i, tk_kind[i], tk_val[i], ek[i], ev[i]);
      end
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    test_reset();
    test_assign();
    test_op2();
    test_wrap();
    test_back_to_back();
    test_err_trunc();
    test_keywords();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tokenizer.md
TOKENIZER -- requirements
Module: tokenizer

Interface
REQ-001 SHALL have parameter MAX_ID_LEN, default 8, the maximum number of identifier characters retained.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  a source byte is offered.
REQ-005 SHALL have port in_ready  output  1  the tokenizer accepts the offered byte.
REQ-006 SHALL have port in_data  input  8  ASCII source byte.
REQ-007 SHALL have port in_last  input  1  the byte is the final byte of the source text.
REQ-008 SHALL have port out_valid  output  1  a token is presented.
REQ-009 SHALL have port out_ready  input  1  the downstream parser takes the token.
REQ-010 SHALL have port out_kind  output  3  token kind: RESERVED=0, IDENT=1, NUM=2, EOF=3, ERR=4.
REQ-011 SHALL have port out_op  output  5  reserved-word/operator code, valid when out_kind=RESERVED.
REQ-012 SHALL have port out_val  output  32  number value for NUM, or the offending byte zero-extended for ERR.
REQ-013 SHALL have port out_name  output  8*MAX_ID_LEN  identifier bytes, first character in bits [7:0], unused bytes zero.
REQ-014 SHALL have port out_len  output  4  number of valid bytes in out_name.

Function
REQ-015 SHALL transfer a byte only on in_valid&&in_ready, and a token only on out_valid&&out_ready.
REQ-016 SHALL drive in_ready = !replay_valid && !eof_pend && (!out_valid || out_ready).
REQ-017 SHALL hold out_valid and all out_* fields stable until the token handshake completes.
REQ-018 SHALL implement states SCAN, NUM, IDENT and OP2; SCAN skips space, tab, LF and CR.
REQ-019 In SCAN: a digit SHALL enter NUM; a letter or '_' SHALL enter IDENT; '<', '>', '=' or '!' SHALL enter OP2; a single-character operator SHALL emit a token.
REQ-020 Single-character operator codes SHALL be: + 1, - 2, * 3, / 4, ( 5, ) 6, { 7, } 8, ; 9, , 10, < 11, > 12, = 13.
REQ-021 Two-character operator codes SHALL be: <= 14, >= 15, == 16, != 17.
REQ-022 Keyword codes SHALL be: return 18, if 19, else 20, for 21, while 22.
REQ-023 NUM SHALL accumulate val = val*10 + digit modulo 2^32, so overflow wraps silently.
REQ-024 IDENT SHALL accept letters, digits and '_'.
REQ-025 IDENT SHALL store at most MAX_ID_LEN bytes, discarding later characters while out_len saturates at MAX_ID_LEN.
REQ-026 An untruncated IDENT whose bytes exactly match a keyword SHALL be emitted as RESERVED with the keyword code.
REQ-027 The byte that terminates NUM or IDENT, or a second OP2 byte other than '=', SHALL be consumed into a one-entry replay register together with its in_last bit.
REQ-028 The replay register SHALL be processed in SCAN on the following cycle, before any new input byte.
REQ-029 A lone '!' and any other unrecognised byte SHALL emit ERR with out_val equal to the byte value; tokenizing SHALL continue.
REQ-030 A token SHALL be registered onto the outputs in the cycle after its final or terminating byte is accepted, giving latency 1.
REQ-031 When an in_last byte completes or terminates a token, that token SHALL be emitted first, any replayed byte's token next, and EOF last.
REQ-032 After the EOF handshake, the tokenizer SHALL return to SCAN with cleared accumulators, ready for the next source text.
REQ-033 Whitespace carrying in_last SHALL produce EOF directly.

Reset
REQ-034 On rst, the tokenizer SHALL clear out_valid to 0, drive in_ready to 0 while rst is high, and zero out_kind, out_op, out_val, out_name and out_len.
REQ-035 On rst, the tokenizer SHALL clear replay_valid and eof_pend and return the state to SCAN.
REQ-036 A reset mid-token SHALL discard the partial token with no output emitted.

Structure
REQ-037 Token kinds, operator/keyword codes and the state enumeration SHALL live in package tokenizer_pkg.
REQ-038 Keyword matching SHALL be a combinational sub-module tok_classify that maps out_name and out_len to {is_kw, op}.

Verification
REQ-039 Input "a=3;" with in_last on ';' SHALL produce IDENT "a"/len 1, then RESERVED 13, then NUM 3, then RESERVED 9, then EOF.
REQ-040 Input "x<=10 <y" SHALL produce IDENT x, RESERVED 14, NUM 10, RESERVED 11, IDENT y, then EOF.
REQ-041 Input "return 4294967297;" SHALL produce RESERVED 18, then NUM 1, then RESERVED 9, then EOF.
REQ-042 Input "1+2" with out_ready low for 5 cycles per token SHALL keep outputs stable, hold in_ready low, and lose no token.
REQ-043 Input "ab@ whilex abcdefghij" SHALL produce IDENT ab, then ERR 0x40, then IDENT "whilex", then IDENT "abcdefgh"/len 8, then EOF.
REQ-044 Asserting rst after "12" and then sending "7" with in_last SHALL produce only NUM 7 and EOF.
